// File: rtl/fsm_deco_seq.sv
// Sequenced instruction decoder: valid/ready accept, then DECODE/READ/EXEC/LOAD_WAIT/WB walk.
// Optional FSM_DECO_RETIRE_CNT_EN adds a wrapping count of retired instructions (retire_cnt).
//
// state     | meaning
// S_IDLE    | ready for a new instruction
// S_DECODE  | fields latched, pick the path
// S_READ    | register-file read strobe
// S_EXEC    | ALU cycle
// S_LOAD_WAIT | load_req held until ack or timeout
// S_WB      | register-file write strobe
module fsm_deco_seq #(
   parameter int ADDR_W       = 2,
   parameter int LOAD_TIMEOUT = 15,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [2:0]        opcode,
   input  logic [ADDR_W-1:0] operand1,
   input  logic [ADDR_W-1:0] operand2,
   output logic [2:0]        alu_opcode,
   output logic [ADDR_W-1:0] rd_addr1,
   output logic [ADDR_W-1:0] rd_addr2,
   output logic              rd_en,
   output logic [ADDR_W-1:0] wrt_addr,
   output logic              wrt_en,
   output logic              load_data,
   output logic              load_req,
   input  logic              load_ack,
   output logic              load_err,
   output logic              busy
`ifdef FSM_DECO_RETIRE_CNT_EN
   ,output logic [CNT_W-1:0] retire_cnt
`endif
);

   localparam int LC_W = ($clog2(LOAD_TIMEOUT + 1) > 4) ? $clog2(LOAD_TIMEOUT + 1) : 4;
   localparam logic [LC_W-1:0] LC_LAST = LC_W'(LOAD_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_READ, S_EXEC, S_LOAD_WAIT, S_WB
   } state_t;

   state_t          state, state_nxt;
   logic            rst_done;
   logic [LC_W-1:0] load_cnt;
   logic            accept;

   assign busy        = (state != S_IDLE);
   assign instr_ready = (state == S_IDLE) && rst_done;
   assign accept      = instr_valid && instr_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         rst_done   <= 1'b0;
         load_cnt   <= '0;
         alu_opcode <= '0;
         rd_addr1   <= '0;
         rd_addr2   <= '0;
         wrt_addr   <= '0;
         load_data  <= 1'b0;
      end else begin
         state    <= state_nxt;
         rst_done <= 1'b1;
         load_cnt <= (state == S_LOAD_WAIT) ? load_cnt + 1'b1 : '0;
         if (accept) begin
            alu_opcode <= opcode;
            // fields an opcode does not use keep their previous values
            case (opcode)
               3'b001: begin
                  wrt_addr  <= operand1;
                  load_data <= 1'b0;
               end
               3'b010, 3'b011: begin
                  rd_addr1  <= operand1;
                  wrt_addr  <= operand1;
                  load_data <= 1'b0;
               end
               3'b100: begin
                  wrt_addr  <= operand1;
                  load_data <= 1'b1;
               end
               3'b101: begin
                  rd_addr1 <= operand1;
                  rd_addr2 <= operand2;
               end
               3'b110: begin
                  rd_addr1  <= operand1;
                  rd_addr2  <= operand2;
                  wrt_addr  <= operand1;
                  load_data <= 1'b0;
               end
               3'b111: begin
                  rd_addr1  <= operand2;
                  wrt_addr  <= operand1;
                  load_data <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      wrt_en    = 1'b0;
      load_req  = 1'b0;
      load_err  = 1'b0;
      case (state)
         S_IDLE:
            if (accept) state_nxt = S_DECODE;
         S_DECODE:
            case (alu_opcode)
               3'b000:  state_nxt = S_IDLE;
               3'b001:  state_nxt = S_EXEC;
               3'b100:  state_nxt = S_LOAD_WAIT;
               default: state_nxt = S_READ;
            endcase
         S_READ: begin
            rd_en     = 1'b1;
            state_nxt = S_EXEC;
         end
         S_EXEC:
            state_nxt = (alu_opcode == 3'b101) ? S_IDLE : S_WB;
         S_LOAD_WAIT: begin
            load_req = 1'b1;
            // ack on the final counted cycle still wins over the timeout
            if (load_ack) begin
               state_nxt = S_WB;
            end else if (load_cnt == LC_LAST) begin
               load_err  = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_WB: begin
            wrt_en    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

`ifdef FSM_DECO_RETIRE_CNT_EN
   logic retire;
   assign retire = busy && (state_nxt == S_IDLE) && !load_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         retire_cnt <= '0;
      else if (retire) retire_cnt <= retire_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_fsm_deco_seq.sv
// Directed bench for fsm_deco_seq: per-cycle strobe masks after each accept vs hand-computed masks.
module tb_fsm_deco_seq;
   localparam int NCYC = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       instr_valid;
   logic       instr_ready;
   logic [2:0] opcode;
   logic [1:0] operand1, operand2;
   logic [2:0] alu_opcode;
   logic [1:0] rd_addr1, rd_addr2, wrt_addr;
   logic       rd_en, wrt_en, load_data, load_req, load_ack, load_err, busy;
`ifdef FSM_DECO_RETIRE_CNT_EN
   logic [1:0] retire_cnt;
`endif

   int tests  = 0;
   int errors = 0;

   logic [31:0] rd_log, wr_log, rdy_log, req_log, err_log, busy_log;

   fsm_deco_seq #(.ADDR_W(2), .LOAD_TIMEOUT(15), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .opcode(opcode), .operand1(operand1), .operand2(operand2), .alu_opcode(alu_opcode),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_en(rd_en), .wrt_addr(wrt_addr),
      .wrt_en(wrt_en), .load_data(load_data), .load_req(load_req), .load_ack(load_ack),
      .load_err(load_err), .busy(busy)
`ifdef FSM_DECO_RETIRE_CNT_EN
      , .retire_cnt(retire_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] span(input int lo, input int hi);
      logic [31:0] m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [31:0] all_outs();
      return {16'd0, instr_ready, busy, rd_en, wrt_en, load_req, load_err, load_data,
              alu_opcode, rd_addr1, rd_addr2, wrt_addr};
   endfunction

   // Called just after a negedge with the DUT idle; bit k of each log = value in cycle k.
   task automatic run(input logic [2:0] op, input logic [1:0] r1, input logic [1:0] r2,
                      input int ack_cyc, input int hold);
      rd_log = '0; wr_log = '0; rdy_log = '0; req_log = '0; err_log = '0; busy_log = '0;
      instr_valid = 1'b1;
      opcode = op; operand1 = r1; operand2 = r2;
      @(posedge clk);
      for (int k = 1; k <= NCYC; k++) begin
         @(negedge clk);
         if (k == 1) begin
            opcode = 3'b000; operand1 = 2'd0; operand2 = 2'd0;
         end
         if (k == hold) instr_valid = 1'b0;
         load_ack = (k == ack_cyc);
         #1;
         rd_log[k] = rd_en;  wr_log[k] = wrt_en;  rdy_log[k] = instr_ready;
         req_log[k] = load_req; err_log[k] = load_err; busy_log[k] = busy;
      end
      load_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; instr_valid = 1'b0; opcode = '0; operand1 = '0; operand2 = '0; load_ack = 1'b0;
      #12;
      check("reset_outputs", all_outs(), 32'd0);
`ifdef FSM_DECO_RETIRE_CNT_EN
      check("reset_retire", {30'd0, retire_cnt}, 32'd0);
`endif
      @(negedge clk); rst = 1'b0;
      @(negedge clk); #1;
      check("reset_ready", {31'd0, instr_ready}, 32'd1);

      // abort a binary op with a reset pulse in cycle 3
      instr_valid = 1'b1; opcode = 3'b110; operand1 = 2'd2; operand2 = 2'd1;
      @(posedge clk);
      @(negedge clk); instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk); rst = 1'b1; #1;
      check("midrst_outputs", all_outs(), 32'd0);
      @(negedge clk); rst = 1'b0;
      wr_log = '0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk); #1;
         wr_log[k] = wrt_en;
         if (k == 1) check("midrst_ready", {30'd0, instr_ready, busy}, 32'b10);
      end
      check("midrst_no_wb", wr_log, 32'd0);

      run(3'b110, 2'd2, 2'd1, 0, 1);
      check("bin_rd_en", rd_log, span(2, 2));
      check("bin_wrt_en", wr_log, span(4, 4));
      check("bin_ready", rdy_log, span(5, NCYC));
      check("bin_busy", busy_log, span(1, 4));
      check("bin_regs", {18'd0, alu_opcode, rd_addr1, rd_addr2, wrt_addr, 3'd0, load_data},
            {18'd0, 3'd6, 2'd2, 2'd1, 2'd2, 3'd0, 1'b0});

      run(3'b100, 2'd3, 2'd0, 5, 1);
      check("ld_req", req_log, span(2, 5));
      check("ld_wrt_en", wr_log, span(6, 6));
      check("ld_no_rd", rd_log | err_log, 32'd0);
      check("ld_regs", {25'd0, wrt_addr, load_data, rd_addr1, rd_addr2}, {25'd0, 2'd3, 1'b1, 2'd2, 2'd1});

      run(3'b100, 2'd1, 2'd0, 0, 1);
      check("to_req", req_log, span(2, 16));
      check("to_err", err_log, span(16, 16));
      check("to_no_wb", wr_log, 32'd0);
      check("to_ready", rdy_log, span(17, NCYC));

      run(3'b100, 2'd2, 2'd0, 16, 1);
      check("toack_err", err_log, 32'd0);
      check("toack_wrt_en", wr_log, span(17, 17));
      check("toack_addr", {30'd0, wrt_addr}, 32'd2);
`ifdef FSM_DECO_RETIRE_CNT_EN
      check("retire_3", {30'd0, retire_cnt}, 32'd3);
`endif

      run(3'b111, 2'd0, 2'd3, 0, 1);
      check("mov_strobes", rd_log | (wr_log << 8), span(2, 2) | span(12, 12));
      check("mov_regs", {25'd0, rd_addr1, rd_addr2, wrt_addr, load_data}, {25'd0, 2'd3, 2'd1, 2'd0, 1'b0});

      run(3'b101, 2'd1, 2'd2, 0, 1);
      check("cmp_rd_en", rd_log, span(2, 2));
      check("cmp_no_wb", wr_log, 32'd0);
      check("cmp_ready", rdy_log, span(4, NCYC));
      check("cmp_regs", {26'd0, rd_addr1, rd_addr2, wrt_addr}, {26'd0, 2'd1, 2'd2, 2'd0});

      run(3'b000, 2'd3, 2'd3, 0, 1);
      check("nop_strobes", rd_log | wr_log | req_log | err_log, 32'd0);
      check("nop_ready", rdy_log, span(2, NCYC));
`ifdef FSM_DECO_RETIRE_CNT_EN
      check("retire_6", {30'd0, retire_cnt}, 32'd2);
`endif

      run(3'b001, 2'd3, 2'd0, 0, 1);
      check("alu_wr_strobes", rd_log | (wr_log << 8), span(11, 11));
      check("alu_wr_ready", rdy_log, span(4, NCYC));

      // unary op with stray ack and instr_valid held while busy
      run(3'b010, 2'd1, 2'd0, 3, 5);
      check("un_strobes", rd_log | (wr_log << 8) | req_log, span(2, 2) | span(12, 12));
      check("un_ready", rdy_log, span(5, NCYC));
      check("un_regs", {26'd0, rd_addr1, wrt_addr, alu_opcode[1:0]}, {26'd0, 2'd1, 2'd1, 2'd2});
`ifdef FSM_DECO_RETIRE_CNT_EN
      check("retire_8", {30'd0, retire_cnt}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
